// File: rtl/sn74_arb_defs.sv
// Purpose : shared definitions for the tristate-bus arbiter family (FSM encodings, counter width).
// Latency : n/a (definitions only).
// Backpr. : n/a.
package sn74_arb_defs;

  // Arbiter FSM encodings; 2'd3 is unreachable and is decoded as IDLE.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_GRANT = 2'd1;
  localparam logic [1:0] ST_TURN  = 2'd2;

  // Width of the hold and dead-time counters (limits DEAD and MAXHOLD to 15).
  localparam int CW = 4;

endpackage

// File: rtl/sn74_tribus_arb_if.sv
// Purpose : bundles the request/grant side of the tristate-bus arbiter.
// Latency : n/a (wiring only).
// Backpr. : none; req is level-held by requesters, gnt drives buffer enables.
// Ports   : req[N] requests, gnt[N] buffer enables, busy, owner[OW], preempt.
//           master = arbiter side (drives gnt/busy/owner/preempt), slave = requester/board side.
interface sn74_tribus_arb_if #(
  parameter int N  = 4,
  parameter int OW = 2
);

  logic [N-1:0]  req;
  logic [N-1:0]  gnt;
  logic          busy;
  logic [OW-1:0] owner;
  logic          preempt;

  modport master (
    input  req,
    output gnt,
    output busy,
    output owner,
    output preempt
  );

  modport slave (
    output req,
    input  gnt,
    input  busy,
    input  owner,
    input  preempt
  );

endinterface

// File: rtl/sn74_rr_pick.sv
// Purpose : combinational round-robin picker; first set request scanning ptr, ptr+1, ... mod N.
// Latency : 0 cycles (pure combinational).
// Backpr. : none.
// Ports   : req[N] candidate requests, ptr[OW] highest-priority index (< N),
//           any = at least one request set, idx[OW] chosen index (0 when any = 0).
module sn74_rr_pick #(
  parameter int N  = 4,
  parameter int OW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [OW-1:0] ptr,
  output logic          any,
  output logic [OW-1:0] idx
);

  // (base + off) mod N, valid for base < N and off < N.
  function automatic logic [OW-1:0] wrap_add(input logic [OW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= N) s = s - N;
    return OW'(s);
  endfunction

  always_comb begin
    any = 1'b0;
    idx = '0;
    for (int k = 0; k < N; k++) begin
      if (!any && req[wrap_add(ptr, k)]) begin
        any = 1'b1;
        idx = wrap_add(ptr, k);
      end
    end
  end

endmodule

// File: rtl/sn74_tribus_arb.sv
// Purpose : round-robin arbiter driving 74LS126-style buffer enables on one shared tristate bus,
//           with DEAD all-zero cycles between owners and optional MAXHOLD preemption.
// Latency : grant 1 clock after the sampled request; all outputs registered.
// Backpr. : none; requests are level-held and simply not granted while the bus is owned or turning.
// Ports   : clk, rst (synchronous, active high), bus (master modport: req in; gnt, busy, owner,
//           preempt out).
module sn74_tribus_arb #(
  parameter int N       = 4,
  parameter int OW      = 2,
  parameter int DEAD    = 1,
  parameter int MAXHOLD = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  sn74_tribus_arb_if.master     bus
);

  import sn74_arb_defs::*;

  // State and output registers
  logic [1:0]    r_state;
  logic [OW-1:0] r_ptr;
  logic [CW-1:0] r_hold;
  logic [CW-1:0] r_dead;
  logic [N-1:0]  r_gnt;
  logic [OW-1:0] r_owner;
  logic          r_busy;
  logic          r_preempt;

  // Next-state / next-output wires
  logic [1:0]    w_state_nxt;
  logic [OW-1:0] w_ptr_nxt;
  logic [CW-1:0] w_hold_nxt;
  logic [CW-1:0] w_dead_nxt;
  logic [N-1:0]  w_gnt_nxt;
  logic [OW-1:0] w_owner_nxt;
  logic          w_preempt_nxt;

  // Decoded conditions
  logic          w_pick_any;
  logic [OW-1:0] w_pick_idx;
  logic          w_owner_req;
  logic          w_hold_max;
  logic          w_release;
  logic          w_arb_slot;
  logic [OW-1:0] w_owner_inc;

  sn74_rr_pick #(
    .N  (N),
    .OW (OW)
  ) u_pick (
    .req (bus.req),
    .ptr (r_ptr),
    .any (w_pick_any),
    .idx (w_pick_idx)
  );

  assign w_owner_req = bus.req[r_owner];
  assign w_hold_max  = (MAXHOLD != 0) && (r_hold == CW'(MAXHOLD));
  assign w_release   = (r_state == ST_GRANT) && (!w_owner_req || w_hold_max);

  // Arbitration happens in IDLE (and the unreachable code) or on the last dead cycle of TURN.
  assign w_arb_slot  = (r_state == ST_TURN) ? (r_dead == CW'(DEAD)) : (r_state != ST_GRANT);

  // The released owner becomes lowest priority: pointer moves just past it.
  assign w_owner_inc = (r_owner == OW'(N - 1)) ? '0 : r_owner + OW'(1);

  // State register (also holds counters and registered outputs)
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_ptr     <= '0;
      r_hold    <= '0;
      r_dead    <= '0;
      r_gnt     <= '0;
      r_owner   <= '0;
      r_busy    <= 1'b0;
      r_preempt <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_ptr     <= w_ptr_nxt;
      r_hold    <= w_hold_nxt;
      r_dead    <= w_dead_nxt;
      r_gnt     <= w_gnt_nxt;
      r_owner   <= w_owner_nxt;
      r_busy    <= |w_gnt_nxt;
      r_preempt <= w_preempt_nxt;
    end
  end

  // Next-state logic: FSM, round-robin pointer, hold and dead counters
  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_hold_nxt  = r_hold;
    w_dead_nxt  = r_dead;
    case (r_state)
      ST_GRANT: begin
        if (w_release) begin
          w_state_nxt = ST_TURN;
          w_ptr_nxt   = w_owner_inc;
          w_hold_nxt  = '0;
          w_dead_nxt  = CW'(1);
        end else if (r_hold != '1) begin
          // Saturate so an unlimited hold never wraps back into the MAXHOLD compare.
          w_hold_nxt = r_hold + CW'(1);
        end
      end
      ST_TURN: begin
        if (!w_arb_slot) begin
          w_dead_nxt = r_dead + CW'(1);
        end else begin
          w_dead_nxt  = '0;
          w_state_nxt = w_pick_any ? ST_GRANT : ST_IDLE;
          w_hold_nxt  = w_pick_any ? CW'(1) : '0;
        end
      end
      default: begin
        w_state_nxt = w_pick_any ? ST_GRANT : ST_IDLE;
        w_hold_nxt  = w_pick_any ? CW'(1) : '0;
        w_dead_nxt  = '0;
      end
    endcase
  end

  // Next-output logic: buffer enables, owner index, preempt pulse
  always_comb begin
    w_gnt_nxt     = r_gnt;
    w_owner_nxt   = r_owner;
    w_preempt_nxt = 1'b0;
    if (r_state == ST_GRANT) begin
      if (w_release) begin
        w_gnt_nxt     = '0;
        w_owner_nxt   = '0;
        // Owner still wants the bus, so the drop is due to the hold limit.
        w_preempt_nxt = w_owner_req;
      end
    end else if (w_arb_slot && w_pick_any) begin
      w_gnt_nxt   = N'(1) << w_pick_idx;
      w_owner_nxt = w_pick_idx;
    end else begin
      w_gnt_nxt   = '0;
      w_owner_nxt = '0;
    end
  end

  assign bus.gnt     = r_gnt;
  assign bus.busy    = r_busy;
  assign bus.owner   = r_owner;
  assign bus.preempt = r_preempt;

endmodule

// File: tb/tb_sn74_tribus_arb.sv
module tb_sn74_tribus_arb;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // a: DEAD=1 unlimited hold; b: DEAD=1 MAXHOLD=4; c: DEAD=3 unlimited hold
  sn74_tribus_arb_if #(.N(4), .OW(2)) if_a ();
  sn74_tribus_arb_if #(.N(4), .OW(2)) if_b ();
  sn74_tribus_arb_if #(.N(4), .OW(2)) if_c ();

  sn74_tribus_arb #(.N(4), .OW(2), .DEAD(1), .MAXHOLD(0)) u_a (.clk(clk), .rst(rst), .bus(if_a));
  sn74_tribus_arb #(.N(4), .OW(2), .DEAD(1), .MAXHOLD(4)) u_b (.clk(clk), .rst(rst), .bus(if_b));
  sn74_tribus_arb #(.N(4), .OW(2), .DEAD(3), .MAXHOLD(0)) u_c (.clk(clk), .rst(rst), .bus(if_c));

  logic [3:0] g  [3];
  logic       bz [3];
  logic [1:0] ow [3];
  logic       pe [3];
  assign g[0] = if_a.gnt;  assign bz[0] = if_a.busy; assign ow[0] = if_a.owner; assign pe[0] = if_a.preempt;
  assign g[1] = if_b.gnt;  assign bz[1] = if_b.busy; assign ow[1] = if_b.owner; assign pe[1] = if_b.preempt;
  assign g[2] = if_c.gnt;  assign bz[2] = if_c.busy; assign ow[2] = if_c.owner; assign pe[2] = if_c.preempt;

  typedef struct {
    int         d;
    logic [3:0] gnt;
    logic       pre;
    string      tag;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  bit   started = 1'b0;
  int   dead_of [3] = '{1, 1, 3};
  int   gap     [3] = '{99, 99, 99};
  logic [3:0] prev_g [3] = '{4'b0, 4'b0, 4'b0};
  logic       prev_b [3] = '{1'b0, 1'b0, 1'b0};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] idx_of(input logic [3:0] v);
    logic [1:0] r;
    r = 2'd0;
    for (int i = 0; i < 4; i++) if (v[i]) r = 2'(i);
    return r;
  endfunction

  // Drive one cycle of stimulus and record what the selected DUT must show after the next edge.
  task automatic drv(input int d, input logic r, input logic [3:0] rq,
                     input logic [3:0] eg, input logic ep, input string tag);
    exp_t e;
    @(negedge clk);
    rst      = r;
    if_a.req = (d == 0) ? rq : 4'b0;
    if_b.req = (d == 1) ? rq : 4'b0;
    if_c.req = (d == 2) ? rq : 4'b0;
    e.d = d; e.gnt = eg; e.pre = ep; e.tag = tag;
    q.push_back(e);
  endtask

  // Monitor: scoreboard pop plus per-cycle invariants on all three DUTs.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (rst) started = 1'b1;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk({e.tag, ".gnt"},     32'(g[e.d]),  32'(e.gnt));
      chk({e.tag, ".busy"},    32'(bz[e.d]), 32'(|e.gnt));
      chk({e.tag, ".owner"},   32'(ow[e.d]), 32'(idx_of(e.gnt)));
      chk({e.tag, ".preempt"}, 32'(pe[e.d]), 32'(e.pre));
    end
    if (started) begin
      for (int d = 0; d < 3; d++) begin
        chk("inv.onehot", 32'($countones(g[d]) <= 1), 32'(1));
        if (prev_g[d] != 4'b0 && g[d] != 4'b0)
          chk("inv.nohop", 32'(g[d]), 32'(prev_g[d]));
        if (rst) begin
          gap[d] = 99;
        end else if (bz[d]) begin
          if (!prev_b[d]) chk("inv.deadgap", 32'(gap[d] >= dead_of[d]), 32'(1));
          gap[d] = 0;
        end else if (gap[d] < 99) begin
          gap[d] = gap[d] + 1;
        end
        prev_g[d] = g[d];
        prev_b[d] = bz[d];
      end
    end
  end

  logic [3:0] rr_req [13] = '{4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0010, 4'b0100, 4'b0100,
                              4'b0100, 4'b1000, 4'b1000, 4'b1000, 4'b0001, 4'b0001};
  logic [3:0] rr_gnt [13] = '{4'b0001, 4'b0001, 4'b0000, 4'b0010, 4'b0010, 4'b0000, 4'b0100,
                              4'b0100, 4'b0000, 4'b1000, 4'b1000, 4'b0000, 4'b0001};
  logic [3:0] pm_gnt [14] = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0010, 4'b0010,
                              4'b0010, 4'b0010, 4'b0000, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
  logic [3:0] dt_req [12] = '{4'b0100, 4'b0100, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0000,
                              4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0010};
  logic [3:0] dt_gnt [12] = '{4'b0100, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0000,
                              4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0010};
  logic [3:0] sg_req [11] = '{4'b0010, 4'b0010, 4'b0000, 4'b0010, 4'b0000, 4'b0000, 4'b0000,
                              4'b0000, 4'b0000, 4'b0000, 4'b0000};
  logic [3:0] sg_gnt [11] = '{4'b0010, 4'b0010, 4'b0000, 4'b0010, 4'b0000, 4'b0000, 4'b0000,
                              4'b0000, 4'b0000, 4'b0000, 4'b0000};

  initial begin
    if_a.req = 4'b0; if_b.req = 4'b0; if_c.req = 4'b0;

    // Reset held two cycles with all requests high, then first grant goes to index 0.
    drv(0, 1'b1, 4'b1111, 4'b0000, 1'b0, "reset0");
    drv(0, 1'b1, 4'b1111, 4'b0000, 1'b0, "reset1");
    drv(0, 1'b0, 4'b1111, 4'b0001, 1'b0, "reset_first");

    // Round robin across all four owners, DEAD=1.
    drv(0, 1'b1, 4'b0000, 4'b0000, 1'b0, "rr_rst");
    for (int i = 0; i < 13; i++) drv(0, 1'b0, rr_req[i], rr_gnt[i], 1'b0, "rr");

    // Reset in the middle of a grant: drop at that edge, next grant with ptr back at 0.
    drv(0, 1'b1, 4'b0000, 4'b0000, 1'b0, "mid_rst0");
    drv(0, 1'b0, 4'b0100, 4'b0100, 1'b0, "mid_gnt");
    drv(0, 1'b1, 4'b0100, 4'b0000, 1'b0, "mid_rst");
    drv(0, 1'b0, 4'b0110, 4'b0010, 1'b0, "mid_after");

    // Self re-grant after one dead cycle, then long idle.
    drv(0, 1'b1, 4'b0000, 4'b0000, 1'b0, "sg_rst");
    for (int i = 0; i < 11; i++) drv(0, 1'b0, sg_req[i], sg_gnt[i], 1'b0, "selfgnt");

    // MAXHOLD=4 preemption with two requesters held.
    drv(1, 1'b1, 4'b0000, 4'b0000, 1'b0, "pm_rst");
    for (int i = 0; i < 14; i++)
      drv(1, 1'b0, 4'b0011, pm_gnt[i], (i == 4 || i == 9), "preempt");

    // DEAD=3 turnaround and requests ignored on non-final dead cycles.
    drv(2, 1'b1, 4'b0000, 4'b0000, 1'b0, "dt_rst");
    for (int i = 0; i < 12; i++) drv(2, 1'b0, dt_req[i], dt_gnt[i], 1'b0, "deadtime");

    drv(2, 1'b0, 4'b0000, 4'b0000, 1'b0, "tail");
    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    @(negedge clk);
    chk("drain", 32'(q.size()), 32'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
